// File: rtl/delta_fpu_arbiter.sv
// delta_fpu_arbiter: shares one FP sub/mul/add unit between the delta and delta-2nd controllers.
// Define DELTA_FPU_ROUND_ROBIN_EN for round-robin contention; otherwise req0 has fixed priority.
module delta_fpu_arbiter #(
    parameter int         DATA_WIDTH = 32,
    parameter logic [3:0] LAT_SUB    = 4'd10,
    parameter logic [3:0] LAT_MUL    = 4'd10,
    parameter logic [3:0] LAT_ADD    = 4'd10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [1:0]            op0,
    input  logic [1:0]            op1,
    input  logic [DATA_WIDTH-1:0] a0,
    input  logic [DATA_WIDTH-1:0] b0,
    input  logic [DATA_WIDTH-1:0] a1,
    input  logic [DATA_WIDTH-1:0] b1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  done0,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] res0,
    output logic [DATA_WIDTH-1:0] res1,
    output logic                  fpu_sub_en,
    output logic                  fpu_mul_en,
    output logic                  fpu_add_en,
    output logic [DATA_WIDTH-1:0] fpu_a,
    output logic [DATA_WIDTH-1:0] fpu_b,
    input  logic [DATA_WIDTH-1:0] fpu_result,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t                state;
    logic                  owner;
    logic [1:0]            op;
    logic [3:0]            cnt;
    logic                  pick;
    logic [1:0]            sel_op;
    logic [DATA_WIDTH-1:0] sel_a, sel_b;
    logic [3:0]            sel_lat;
`ifdef DELTA_FPU_ROUND_ROBIN_EN
    logic last;
    assign pick = (req0 && req1) ? ~last : ~req0;
`else
    assign pick = ~req0;
`endif
    assign sel_op = pick ? op1 : op0;
    assign sel_a  = pick ? a1 : a0;
    assign sel_b  = pick ? b1 : b0;
    // illegal op gets a single EXEC cycle so the requester still sees done
    always_comb sel_lat = sel_op == 2'd0 ? LAT_SUB - 4'd1 :
                          sel_op == 2'd1 ? LAT_MUL - 4'd1 :
                          sel_op == 2'd2 ? LAT_ADD - 4'd1 : 4'd0;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            op         <= 2'd0;
            cnt        <= 4'd0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            res0       <= '0;
            res1       <= '0;
            fpu_sub_en <= 1'b0;
            fpu_mul_en <= 1'b0;
            fpu_add_en <= 1'b0;
            fpu_a      <= '0;
            fpu_b      <= '0;
            busy       <= 1'b0;
`ifdef DELTA_FPU_ROUND_ROBIN_EN
            last       <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: if (req0 || req1) begin
                    owner      <= pick;
                    op         <= sel_op;
                    fpu_a      <= sel_a;
                    fpu_b      <= sel_b;
                    cnt        <= sel_lat;
                    gnt0       <= ~pick;
                    gnt1       <= pick;
                    fpu_sub_en <= sel_op == 2'd0;
                    fpu_mul_en <= sel_op == 2'd1;
                    fpu_add_en <= sel_op == 2'd2;
                    busy       <= 1'b1;
                    state      <= EXEC;
`ifdef DELTA_FPU_ROUND_ROBIN_EN
                    last       <= pick;
`endif
                end
                EXEC: if (cnt == 4'd0) begin
                    if (owner) res1 <= op == 2'd3 ? '0 : fpu_result;
                    else       res0 <= op == 2'd3 ? '0 : fpu_result;
                    fpu_sub_en <= 1'b0;
                    fpu_mul_en <= 1'b0;
                    fpu_add_en <= 1'b0;
                    done0      <= ~owner;
                    done1      <= owner;
                    state      <= DONE;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                DONE: begin
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_delta_fpu_arbiter.sv
// tb_delta_fpu_arbiter: directed + random checks of delta_fpu_arbiter against a slot-schedule model.
module tb_delta_fpu_arbiter;
    localparam int LS = 5, LM = 10, LA = 7;
`ifdef DELTA_FPU_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic clk = 1'b0, rst_n, req0, req1;
    logic [1:0] op0, op1;
    logic [31:0] a0, b0, a1, b1, res0, res1, fpu_a, fpu_b, fpu_result;
    logic gnt0, gnt1, done0, done1, fpu_sub_en, fpu_mul_en, fpu_add_en, busy;

    typedef struct {
        logic        ch;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } slot_t;
    slot_t sched[$];
    int checks = 0, errors = 0;
    logic last = 1'b1;
    logic [31:0] exp_res0 = 0, exp_res1 = 0, exp_fa = 0, exp_fb = 0;

    delta_fpu_arbiter #(.DATA_WIDTH(32), .LAT_SUB(4'(LS)), .LAT_MUL(4'(LM)), .LAT_ADD(4'(LA))) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .res0(res0), .res1(res1), .fpu_sub_en(fpu_sub_en), .fpu_mul_en(fpu_mul_en), .fpu_add_en(fpu_add_en),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_result(fpu_result), .busy(busy));

    always #5 clk = ~clk;

    function automatic logic [31:0] unit(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o == 2'd0) return x - y;
        if (o == 2'd1) return (x == 32'h40000000 && y == 32'h40400000) ? 32'h40C00000 : x * y;
        if (o == 2'd2) return x + y;
        return 32'h0;
    endfunction

    // shared unit model: output only meaningful while an enable is high
    always_comb fpu_result = fpu_sub_en ? unit(2'd0, fpu_a, fpu_b) :
                             fpu_mul_en ? unit(2'd1, fpu_a, fpu_b) :
                             fpu_add_en ? unit(2'd2, fpu_a, fpu_b) : 32'hDEADBEEF;

    function automatic int lat(input logic [1:0] o);
        return o == 2'd0 ? LS : o == 2'd1 ? LM : o == 2'd2 ? LA : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] outs();
        return {24'd0, gnt0, gnt1, done0, done1, fpu_sub_en, fpu_mul_en, fpu_add_en, busy};
    endfunction

    task automatic chk_all(input string tag, input logic [7:0] vec);
        chk({tag, ".ctl"}, outs(), {24'd0, vec});
        chk({tag, ".fpu_a"}, fpu_a, exp_fa);
        chk({tag, ".fpu_b"}, fpu_b, exp_fb);
        chk({tag, ".res0"}, res0, exp_res0);
        chk({tag, ".res1"}, res1, exp_res1);
    endtask

    task automatic push(input logic ch);
        sched.push_back('{ch, ch ? op1 : op0, ch ? a1 : a0, ch ? b1 : b0});
        last = ch;
    endtask

    // each slot: LAT EXEC cycles, one DONE cycle, one IDLE cycle
    task automatic run_sched(input string tag, input bit hold, input bit toggle);
        foreach (sched[s]) begin
            slot_t t;
            int l;
            t = sched[s];
            l = lat(t.op);
            for (int j = 0; j < l + 2; j++) begin
                bit ex, dn, id;
                @(negedge clk);
                ex = j < l;
                dn = j == l;
                id = j == l + 1;
                if (j == 0) begin
                    exp_fa = t.a;
                    exp_fb = t.b;
                end
                if (dn && t.ch) exp_res1 = unit(t.op, t.a, t.b);
                if (dn && !t.ch) exp_res0 = unit(t.op, t.a, t.b);
                chk_all(tag, {!id && !t.ch, !id && t.ch, dn && !t.ch, dn && t.ch,
                              ex && t.op == 2'd0, ex && t.op == 2'd1, ex && t.op == 2'd2, !id});
                if (dn && (!hold || s == sched.size() - 1)) begin
                    if (hold || !t.ch) req0 = 1'b0;
                    if (hold || t.ch) req1 = 1'b0;
                end
                if (ex && toggle) begin
                    if (t.ch) begin
                        a1 = $urandom; b1 = $urandom; op1 = 2'($urandom);
                    end else begin
                        a0 = $urandom; b0 = $urandom; op0 = 2'($urandom);
                    end
                end
            end
        end
    endtask

    task automatic arb(input string tag, input logic [1:0] mask, input bit hold, input int n);
        logic w;
        sched.delete();
        if (hold) begin
            for (int k = 0; k < n; k++) push(RR ? ~last : 1'b0);
        end else if (mask == 2'b11) begin
            w = RR ? ~last : 1'b0;
            push(w);
            push(~w);
        end else begin
            push(mask == 2'b10);
        end
        req0 = mask[0];
        req1 = mask[1];
        run_sched(tag, hold, !hold);
    endtask

    initial begin
        rst_n = 1'b0; req0 = 0; req1 = 0; op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        repeat (3) @(negedge clk);
        chk_all("reset", 8'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all("idle", 8'd0);

        op0 = 2'd2; a0 = 32'd100; b0 = 32'd23; op1 = 2'd2; a1 = 32'd7; b1 = 32'd9;
        arb("burst1", 2'b11, 1'b0, 2);
        op0 = 2'd1; a0 = 32'h40000000; b0 = 32'h40400000;
        arb("mul0", 2'b01, 1'b0, 1);
        op0 = 2'd2; a0 = 32'd1; b0 = 32'd2; op1 = 2'd2; a1 = 32'd30; b1 = 32'd40;
        arb("burst2", 2'b11, 1'b0, 2);
        op0 = 2'd3; a0 = 32'h12345678; b0 = 32'h9abcdef0;
        arb("illegal0", 2'b01, 1'b0, 1);
        op0 = 2'd2; a0 = 32'd5; b0 = 32'd6; op1 = 2'd0; a1 = 32'd50; b1 = 32'd8;
        arb("hold", 2'b11, 1'b1, 4);

        for (int i = 0; i < 24; i++) begin
            op0 = 2'($urandom); op1 = 2'($urandom);
            a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            arb("rand", 2'($urandom_range(1, 3)), 1'b0, 1);
        end

        op0 = 2'd0; a0 = 32'd77; b0 = 32'd11;
        req0 = 1'b1;
        exp_fa = a0; exp_fb = b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk_all("rstmid.exec", 8'b1000_1001);
        end
        @(negedge clk);
        rst_n = 1'b0;
        req0 = 1'b0;
        last = 1'b1; exp_res0 = 0; exp_res1 = 0; exp_fa = 0; exp_fb = 0;
        @(negedge clk);
        chk_all("rstmid.rst", 8'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all("rstmid.idle", 8'd0);

        op0 = 2'd0; a0 = 32'd9; b0 = 32'd4; op1 = 2'd1; a1 = 32'd3; b1 = 32'd5;
        arb("post_rst", 2'b11, 1'b0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
